// File: rtl/spi_id_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// spi_id_reader
//
// Reads the identification bytes of the platform SPI flash (M25P16 behind
// cs_prom_n). A start request sends OPCODE MSB first, then clocks in N_BYTES
// response bytes in SPI mode 0. SPICLK runs at CCLK / (2*CLK_DIV). Between
// transfers the flash stays deselected for at least 2*CLK_DIV cycles. With
// repeat_en set, the reader polls the flash continuously.
//
// Ports
//   CCLK       system clock; all logic runs on its rising edge
//   reset_n    asynchronous active-low reset
//   start      request pulse, only honoured while idle
//   repeat_en  restart automatically after each completed read
//   sel        selects which response byte drives led (0 = last byte received)
//   SPIMISO    serial data from the flash
//   SPICLK     SPI clock, idles low
//   SPIMOSI    serial data to the flash
//   cs_prom_n  flash chip select, active low
//   busy       high from the accepted start until the return to idle
//   done       one-cycle pulse when id_data is refreshed
//   id_data    last complete response, first received byte in the MSBs
//   led        selected response byte, 8'hFF when sel is out of range
//   id_ascii   uppercase ASCII hex of id_data, first high nibble in the MSBs
// -----------------------------------------------------------------------------
module spi_id_reader #(
    parameter int         CLK_DIV = 4,
    parameter int         N_BYTES = 3,
    parameter logic [7:0] OPCODE  = 8'h9F,
    parameter int         SEL_W   = 2
) (
    input  logic                    CCLK,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    repeat_en,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    SPIMISO,
    output logic                    SPICLK,
    output logic                    SPIMOSI,
    output logic                    cs_prom_n,
    output logic                    busy,
    output logic                    done,
    output logic [8*N_BYTES-1:0]    id_data,
    output logic [7:0]              led,
    output logic [16*N_BYTES-1:0]   id_ascii
);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        CMD,
        READ,
        CS_HOLD,
        GAP
    } state_t;

    localparam int         BITS     = 8 * N_BYTES;
    localparam logic [8:0] HALF_END = 9'(CLK_DIV - 1);
    localparam logic [8:0] GAP_END  = 9'(2 * CLK_DIV - 1);
    localparam logic [5:0] READ_END = 6'(BITS - 1);

    state_t          state;
    logic [8:0]      div_cnt;
    logic [5:0]      bit_cnt;
    logic [BITS-1:0] shadow;
    logic            half_tick;

    // One half SPICLK period (CLK_DIV cycles) has elapsed in the current phase.
    assign half_tick = (div_cnt == HALF_END);

    // Transfer sequencer. All bus outputs are registered here so that SPICLK,
    // SPIMOSI and cs_prom_n never glitch. SPIMOSI is only updated on the edge
    // that drives SPICLK low (or before the first rise), so it is stable across
    // every rising edge. The response is collected in a shadow register and
    // only copied to id_data when the transfer has fully completed.
    always_ff @(posedge CCLK or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            shadow    <= '0;
            SPICLK    <= 1'b0;
            SPIMOSI   <= 1'b0;
            cs_prom_n <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            id_data   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CS_SETUP;
                        cs_prom_n <= 1'b0;
                        busy      <= 1'b1;
                        div_cnt   <= '0;
                    end
                end
                CS_SETUP: begin
                    if (half_tick) begin
                        state   <= CMD;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        SPIMOSI <= OPCODE[7];
                    end else begin
                        div_cnt <= div_cnt + 9'd1;
                    end
                end
                CMD, READ: begin
                    if (!half_tick) begin
                        div_cnt <= div_cnt + 9'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!SPICLK) begin
                            // Rising edge: the flash output has been stable
                            // since the previous falling edge.
                            SPICLK <= 1'b1;
                            if (state == READ) begin
                                shadow <= {shadow[BITS-2:0], SPIMISO};
                            end
                        end else begin
                            SPICLK  <= 1'b0;
                            bit_cnt <= bit_cnt + 6'd1;
                            if (state == CMD) begin
                                if (bit_cnt == 6'd7) begin
                                    state   <= READ;
                                    bit_cnt <= '0;
                                    SPIMOSI <= 1'b0;
                                end else begin
                                    SPIMOSI <= OPCODE[3'd6 - bit_cnt[2:0]];
                                end
                            end else if (bit_cnt == READ_END) begin
                                state <= CS_HOLD;
                            end
                        end
                    end
                end
                CS_HOLD: begin
                    if (half_tick) begin
                        state     <= GAP;
                        div_cnt   <= '0;
                        cs_prom_n <= 1'b1;
                        id_data   <= shadow;
                        done      <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 9'd1;
                    end
                end
                GAP: begin
                    // repeat_en is looked at only here, so clearing it during
                    // a transfer lets that transfer finish normally.
                    if (div_cnt == GAP_END) begin
                        div_cnt <= '0;
                        if (repeat_en) begin
                            state     <= CS_SETUP;
                            cs_prom_n <= 1'b0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        div_cnt <= div_cnt + 9'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // LED byte select: sel counts bytes back from the last one received, which
    // sits in the least significant byte of id_data.
    always_comb begin
        led = 8'hFF;
        if (int'(sel) < N_BYTES) begin
            led = 8'(id_data >> {sel, 3'b000});
        end
    end

    // Each nibble of id_data becomes one ASCII hex character at the same
    // relative position, so the first byte's high nibble lands in the MSBs.
    for (genvar i = 0; i < 2 * N_BYTES; i++) begin : g_hex
        logic [3:0] nib;
        assign nib = id_data[4*i +: 4];
        assign id_ascii[8*i +: 8] = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
    end

endmodule

// File: tb/tb_spi_id_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_spi_id_reader
//
// Drives two readers: the default configuration (CLK_DIV=4, N_BYTES=3) and a
// minimal one (CLK_DIV=1, N_BYTES=1), each attached to a small M25P16 RDID
// responder (20 20 15). The default instance is compared every cycle against
// a timing model built from the transfer arithmetic; both instances are also
// pinned with hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_spi_id_reader;

    localparam int C1       = 4;
    localparam int N1       = 3;
    localparam int DONE_OFS = C1 * (18 + 16 * N1);
    localparam int GAP_OFS  = DONE_OFS + 2 * C1;

    logic        CCLK = 1'b0;
    logic        reset_n;
    logic        start;
    logic        repeat_en;
    logic [1:0]  sel;
    logic        SPIMISO = 1'b0;
    logic        SPICLK;
    logic        SPIMOSI;
    logic        cs_prom_n;
    logic        busy;
    logic        done;
    logic [23:0] id_data;
    logic [7:0]  led;
    logic [47:0] id_ascii;

    logic        reset2_n;
    logic        start2;
    logic        repeat2_en;
    logic [1:0]  sel2;
    logic        miso2 = 1'b0;
    logic        sclk2;
    logic        mosi2;
    logic        cs2_n;
    logic        busy2;
    logic        done2;
    logic [7:0]  id2;
    logic [7:0]  led2;
    logic [15:0] ascii2;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 CCLK = ~CCLK;

    spi_id_reader dut (
        .CCLK      (CCLK),
        .reset_n   (reset_n),
        .start     (start),
        .repeat_en (repeat_en),
        .sel       (sel),
        .SPIMISO   (SPIMISO),
        .SPICLK    (SPICLK),
        .SPIMOSI   (SPIMOSI),
        .cs_prom_n (cs_prom_n),
        .busy      (busy),
        .done      (done),
        .id_data   (id_data),
        .led       (led),
        .id_ascii  (id_ascii)
    );

    spi_id_reader #(.CLK_DIV(1), .N_BYTES(1)) dut2 (
        .CCLK      (CCLK),
        .reset_n   (reset2_n),
        .start     (start2),
        .repeat_en (repeat2_en),
        .sel       (sel2),
        .SPIMISO   (miso2),
        .SPICLK    (sclk2),
        .SPIMOSI   (mosi2),
        .cs_prom_n (cs2_n),
        .busy      (busy2),
        .done      (done2),
        .id_data   (id2),
        .led       (led2),
        .id_ascii  (ascii2)
    );

    // M25P16 RDID response stream: manufacturer 20h, type 20h, capacity 15h.
    function automatic logic id_bit(input int idx);
        logic [7:0] b;
        case (idx / 8)
            0:       b = 8'h20;
            1:       b = 8'h20;
            2:       b = 8'h15;
            default: b = 8'h00;
        endcase
        return b[3'(7 - idx % 8)];
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        string s;
        s = "0123456789ABCDEF";
        return 8'(s.getc(int'(v)));
    endfunction

    // Flash responder and bus monitor for the default instance. A falling
    // chip select restarts the command; rising SPICLK shifts MOSI in.
    int         f1_cnt = 0;
    logic [7:0] f1_op = 8'h00;
    logic [7:0] mosi_first = 8'h00;
    int         rise_total = 0;
    int         late_ones = 0;
    always @(negedge cs_prom_n or posedge SPICLK) begin
        if (SPICLK !== 1'b1) begin
            f1_cnt = 0;
            f1_op  = 8'h00;
        end else if (cs_prom_n == 1'b0) begin
            if (f1_cnt < 8) begin
                f1_op = {f1_op[6:0], SPIMOSI};
                mosi_first[3'(7 - f1_cnt)] = SPIMOSI;
            end else if (SPIMOSI) begin
                late_ones++;
            end
            f1_cnt++;
            rise_total++;
        end
    end
    always @(negedge SPICLK) begin
        if (cs_prom_n == 1'b0 && f1_cnt >= 8)
            SPIMISO = (f1_op == 8'h9F) ? id_bit(f1_cnt - 8) : 1'b0;
    end

    int cs_bad = 0;
    always @(cs_prom_n) begin
        #1;
        if (SPICLK === 1'b1) cs_bad++;
    end

    // Flash responder for the small instance.
    int         f2_cnt = 0;
    logic [7:0] f2_op = 8'h00;
    always @(negedge cs2_n or posedge sclk2) begin
        if (sclk2 !== 1'b1) begin
            f2_cnt = 0;
            f2_op  = 8'h00;
        end else if (cs2_n == 1'b0) begin
            if (f2_cnt < 8) f2_op = {f2_op[6:0], mosi2};
            f2_cnt++;
        end
    end
    always @(negedge sclk2) begin
        if (cs2_n == 1'b0 && f2_cnt >= 8)
            miso2 = (f2_op == 8'h9F) ? id_bit(f2_cnt - 8) : 1'b0;
    end

    // Transfer-level model of the default instance: it only remembers when
    // the current transfer was accepted, when it completes and when the
    // deselect gap ends, plus the bytes of the last completed response.
    int         cyc = 0;
    logic       m_busy = 1'b0;
    int         m_e = 0;
    int         m_done = -1;
    int         m_gap = -1;
    logic [7:0] m_rx [3] = '{8'h00, 8'h00, 8'h00};
    always @(posedge CCLK or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0;
            m_done = -1;
            m_gap  = -1;
            m_rx   = '{8'h00, 8'h00, 8'h00};
        end else begin
            cyc++;
            if (cyc == m_done) m_rx = '{8'h20, 8'h20, 8'h15};
            if (m_busy && cyc == m_gap) begin
                if (repeat_en) begin
                    m_e    = cyc;
                    m_done = cyc + DONE_OFS;
                    m_gap  = cyc + GAP_OFS;
                end else begin
                    m_busy = 1'b0;
                end
            end else if (!m_busy && start) begin
                m_busy = 1'b1;
                m_e    = cyc;
                m_done = cyc + DONE_OFS;
                m_gap  = cyc + GAP_OFS;
            end
        end
    end

    // Expected {cs_prom_n, SPICLK, SPIMOSI, busy, done, id_data, led, id_ascii}.
    function automatic logic [84:0] model_out(input logic [1:0] s);
        logic [7:0]  op;
        logic [7:0]  e_led;
        logic [47:0] e_ascii;
        logic        act;
        logic        e_sclk;
        logic        e_mosi;
        int          t;
        op      = 8'h9F;
        t       = cyc - m_e;
        act     = m_busy && (cyc < m_done);
        e_sclk  = act && (t >= C1) && (((t - C1) / C1) % 2 == 1);
        e_mosi  = 1'b0;
        if (act && t >= C1 && t < 17 * C1) e_mosi = op[3'(7 - (t - C1) / (2 * C1))];
        e_led   = (int'(s) < N1) ? m_rx[2'(N1 - 1 - int'(s))] : 8'hFF;
        e_ascii = '0;
        for (int i = 0; i < N1; i++)
            e_ascii = {e_ascii[31:0], hex_char(m_rx[2'(i)][7:4]), hex_char(m_rx[2'(i)][3:0])};
        return {!act, e_sclk, e_mosi, m_busy, m_busy && (cyc == m_done),
                m_rx[0], m_rx[1], m_rx[2], e_led, e_ascii};
    endfunction

    task automatic checkOutput(input string name, input logic [84:0] act, input logic [84:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rep, input logic [1:0] s);
        start     = st;
        repeat_en = rep;
        sel       = s;
        @(negedge CCLK);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CCLK);
    endtask

    task automatic waitDone(input string name, input bit second, input int maxc, output int d);
        d = -1;
        for (int k = 0; k < maxc && d < 0; k++) begin
            @(negedge CCLK);
            if ((second ? done2 : done) === 1'b1) d = cyc;
        end
        checkOutput({name, "_seen"}, 85'(d >= 0), 85'(1));
    endtask

    logic [7:0] led_tab [4] = '{8'h15, 8'h20, 8'h20, 8'hFF};

    initial begin
        int e, d, d1, d2, d3, dn, bf, r0, l0, cb0;
        reset_n    = 1'b0;
        reset2_n   = 1'b0;
        start      = 1'b0;
        repeat_en  = 1'b0;
        sel        = 2'd0;
        start2     = 1'b0;
        repeat2_en = 1'b0;
        sel2       = 2'd0;

        fork
            forever begin
                @(negedge CCLK);
                #1;
                if (cmp_en)
                    checkOutput("cycle", {cs_prom_n, SPICLK, SPIMOSI, busy, done, id_data, led, id_ascii},
                                model_out(sel));
            end
        join_none

        // Reset values
        tick(3);
        #1;
        checkOutput("reset_ctrl", 85'({cs_prom_n, SPICLK, SPIMOSI, busy, done}), 85'(5'b10000));
        checkOutput("reset_id", 85'(id_data), 85'(0));
        checkOutput("reset_ascii", 85'(id_ascii), 85'(48'h303030303030));
        checkOutput("reset_led", 85'(led), 85'(0));
        sel = 2'd3;
        #1;
        checkOutput("reset_led_oor", 85'(led), 85'(8'hFF));
        @(negedge CCLK);
        reset_n  = 1'b1;
        reset2_n = 1'b1;
        sel      = 2'd0;
        cmp_en   = 1'b1;
        tick(2);

        // Single read with default parameters
        r0  = rise_total;
        l0  = late_ones;
        cb0 = cs_bad;
        applyStimulus(1'b1, 1'b0, 2'd0);
        e = cyc;
        applyStimulus(1'b0, 1'b0, 2'd0);
        waitDone("t1_done", 1'b0, 400, d);
        checkOutput("t1_latency", 85'(d - e), 85'(264));
        checkOutput("t1_id", 85'(id_data), 85'(24'h202015));
        @(negedge CCLK);
        checkOutput("t1_done_width", 85'(done), 85'(0));
        for (int k = 0; k < 4; k++) begin
            sel = 2'(k);
            #1;
            checkOutput("t1_led", 85'(led), 85'(led_tab[2'(k)]));
            @(negedge CCLK);
        end
        sel = 2'd0;
        checkOutput("t1_ascii", 85'(id_ascii), 85'(48'h323032303135));
        tick(20);
        checkOutput("t1_rises", 85'(rise_total - r0), 85'(32));
        checkOutput("t1_cmd_bits", 85'(mosi_first), 85'(8'b10011111));
        checkOutput("t1_read_mosi", 85'(late_ones - l0), 85'(0));
        checkOutput("t1_cs_edges", 85'(cs_bad - cb0), 85'(0));

        // Start pulses while busy are ignored
        applyStimulus(1'b1, 1'b0, 2'd1);
        e = cyc;
        applyStimulus(1'b0, 1'b0, 2'd1);
        dn = 0;
        while (cyc < e + 300) begin
            start = (cyc == e + 49 || cyc == e + 199);
            if (done === 1'b1) dn++;
            if (cyc == e + 271) checkOutput("t2_busy_in_gap", 85'(busy), 85'(1));
            if (cyc == e + 272) checkOutput("t2_busy_after_gap", 85'(busy), 85'(0));
            @(negedge CCLK);
        end
        start = 1'b0;
        checkOutput("t2_done_count", 85'(dn), 85'(1));

        // Asynchronous reset in the middle of a transfer
        applyStimulus(1'b1, 1'b0, 2'd0);
        e = cyc;
        applyStimulus(1'b0, 1'b0, 2'd0);
        while (cyc < e + 120) @(negedge CCLK);
        checkOutput("t3_pre_cs", 85'(cs_prom_n), 85'(0));
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("t3_async_ctrl", 85'({cs_prom_n, SPICLK, busy}), 85'(3'b100));
        checkOutput("t3_async_id", 85'(id_data), 85'(0));
        checkOutput("t3_async_ascii", 85'(id_ascii), 85'(48'h303030303030));
        @(negedge CCLK);
        reset_n = 1'b1;
        tick(2);
        applyStimulus(1'b1, 1'b0, 2'd0);
        applyStimulus(1'b0, 1'b0, 2'd0);
        waitDone("t3_restart", 1'b0, 400, d);
        checkOutput("t3_id", 85'(id_data), 85'(24'h202015));
        tick(12);

        // Auto-repeat polling, then clearing repeat_en mid-transfer
        applyStimulus(1'b1, 1'b1, 2'd0);
        applyStimulus(1'b0, 1'b1, 2'd0);
        waitDone("t4_first", 1'b0, 400, d1);
        waitDone("t4_second", 1'b0, 400, d2);
        checkOutput("t4_period", 85'(d2 - d1), 85'(272));
        while (cyc < d2 + 100) @(negedge CCLK);
        repeat_en = 1'b0;
        waitDone("t4_last", 1'b0, 400, d3);
        checkOutput("t4_period_last", 85'(d3 - d2), 85'(272));
        bf = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge CCLK);
            if (busy === 1'b0 && bf < 0) bf = cyc;
        end
        checkOutput("t4_busy_fall", 85'(bf - d3), 85'(8));
        dn = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge CCLK);
            if (done === 1'b1) dn++;
        end
        checkOutput("t4_no_more_done", 85'(dn), 85'(0));

        // Minimal configuration: CLK_DIV=1, N_BYTES=1
        start2 = 1'b1;
        @(negedge CCLK);
        e = cyc;
        start2 = 1'b0;
        waitDone("t5_done", 1'b1, 100, d);
        checkOutput("t5_latency", 85'(d - e), 85'(34));
        checkOutput("t5_id", 85'(id2), 85'(8'h20));
        sel2 = 2'd1;
        #1;
        checkOutput("t5_led_oor", 85'(led2), 85'(8'hFF));
        sel2 = 2'd0;
        #1;
        checkOutput("t5_led0", 85'(led2), 85'(8'h20));
        checkOutput("t5_ascii", 85'(ascii2), 85'(16'h3230));
        tick(10);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
